// File: rtl/tq_buf_ctrl.sv
// Ping-pong controller for a 2-port 32x128 TQ coefficient RAM split into two banks.
// The producer fills one bank while the consumer drains the other, in strict alternation.
module tq_buf_ctrl #(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 5,
  parameter int BANK_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              wr_blk_done,
  output logic              rd_avail,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_vld,
  output logic              rd_last,
  output logic              rd_err,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata
);
  localparam int CW = ADDR_W - 1;
  localparam logic [CW-1:0] LAST = CW'(BANK_WORDS - 1);

  logic [1:0]    full, full_nxt;
  logic          wr_bank, rd_bank;
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic          rd_pend, last_pend;
  logic          rd_fin;

  // Port strobes are also gated by rst so nothing reaches the RAM while in reset.
  assign wr_ready    = ~full[wr_bank];
  assign ram_we      = wr_valid & wr_ready & ~rst;
  assign ram_waddr   = {wr_bank, wr_cnt};
  assign ram_wdata   = wr_data;
  assign wr_blk_done = ram_we & (wr_cnt == LAST);

  assign rd_avail    = full[rd_bank];
  assign ram_rd      = rd_en & rd_avail & ~rst;
  assign ram_raddr   = {rd_bank, rd_cnt};
  assign rd_fin      = ram_rd & (rd_cnt == LAST);

  assign rd_data     = ram_rdata;
  assign rd_data_vld = rd_pend;
  assign rd_last     = last_pend;

  // Writer only targets an empty bank and reader only a full one, so the two
  // updates never hit the same bit.
  always_comb begin
    full_nxt = full;
    if (rd_fin)      full_nxt[rd_bank] = 1'b0;
    if (wr_blk_done) full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full      <= '0;
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      rd_bank   <= 1'b0;
      rd_cnt    <= '0;
      rd_pend   <= 1'b0;
      last_pend <= 1'b0;
      rd_err    <= 1'b0;
    end else begin
      full <= full_nxt;
      if (ram_we) begin
        wr_cnt <= wr_cnt + CW'(1);
        if (wr_cnt == LAST) wr_bank <= ~wr_bank;
      end
      if (ram_rd) begin
        rd_cnt <= rd_cnt + CW'(1);
        if (rd_cnt == LAST) rd_bank <= ~rd_bank;
      end
      rd_pend   <= ram_rd;
      last_pend <= rd_fin;
      if (rd_en & ~rd_avail) rd_err <= 1'b1;
    end
  end

endmodule

// File: doc/tq_buf_ctrl.md
Name: tq_buf_ctrl

Overview:
- Ping-pong buffer controller for the 2-port 32x128 TQ coefficient RAM.
- Splits the RAM into two 16-word banks.
- Accepts 128-bit coefficient words from the TQ datapath (producer) and streams completed blocks to the downstream consumer (reconstruction/CAVLC).
- Sequences RAM write/read ports, tracks bank occupancy and enforces producer/consumer handshakes.

Parameters:
- DATA_W, 128, RAM word width
- ADDR_W, 5, RAM address width; MSB selects bank
- BANK_WORDS, 16, words per block/bank; must equal 2**(ADDR_W-1)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous active-high reset
- wr_valid  in  1  producer word valid
- wr_data  in  DATA_W  producer word
- wr_ready  out  1  controller can accept word this cycle
- wr_blk_done  out  1  one-cycle pulse: last word of a block written
- rd_avail  out  1  a full bank is ready for reading
- rd_en  in  1  consumer read request
- rd_data  out  DATA_W  read word (= ram_rdata)
- rd_data_vld  out  1  rd_data valid this cycle
- rd_last  out  1  with rd_data_vld: last word of block
- rd_err  out  1  sticky: rd_en seen while rd_avail=0
- ram_we  out  1  RAM write enable
- ram_waddr  out  ADDR_W  RAM write address
- ram_wdata  out  DATA_W  RAM write data
- ram_rd  out  1  RAM read enable
- ram_raddr  out  ADDR_W  RAM read address
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after ram_rd

Behaviour:
- State registers:
  - full[1:0]
  - wr_bank, wr_cnt[ADDR_W-2:0]
  - rd_bank, rd_cnt[ADDR_W-2:0]
  - rd_pend (ram_rd delayed one cycle), last_pend, rd_err
- Reset (async, rst=1): all state registers 0.
  - Outputs during reset: wr_ready=1, rd_avail=0, rd_data_vld=0, rd_last=0, wr_blk_done=0, rd_err=0, ram_we=0, ram_rd=0.
- Write path (combinational to RAM, zero latency):
  - wr_ready = ~full[wr_bank].
  - ram_we = wr_valid & wr_ready; ram_waddr = {wr_bank, wr_cnt}; ram_wdata = wr_data.
  - On accept: wr_cnt++.
  - If wr_cnt==BANK_WORDS-1: full[wr_bank]<=1, wr_bank toggles, wr_cnt<=0, and wr_blk_done=1 combinationally in that cycle.
  - wr_valid with wr_ready=0: stall; no RAM write, no counter change.
- Read path:
  - rd_avail = full[rd_bank].
  - ram_rd = rd_en & rd_avail; ram_raddr = {rd_bank, rd_cnt}.
  - On ram_rd: rd_cnt++.
  - If rd_cnt==BANK_WORDS-1: full[rd_bank]<=0, rd_bank toggles, rd_cnt<=0.
  - rd_pend<=ram_rd; last_pend<=ram_rd & (rd_cnt==BANK_WORDS-1).
  - rd_data_vld=rd_pend; rd_last=last_pend; rd_data=ram_rdata.
  - Latency: rd_en accepted in cycle N -> data in cycle N+1.
  - rd_en with rd_avail=0: ignored and rd_err<=1 (cleared only by rst).
- Simultaneous events:
  - Write finishing bank A and read finishing bank B in the same cycle: both full updates apply; the two update different bits.
  - A bank freed by the last read in cycle N gives wr_ready=1 no earlier than N+1, since full is registered. The RAM read of the last word completes at the N edge, so there is no read/write hazard on the same address.
  - Both banks full: wr_ready=0 until the consumer finishes one bank.
  - Both banks empty: rd_avail=0.
- Ordering: blocks are read in write order (strict ping-pong); a bank is never read partially while being written.
- Reset mid-operation: partial blocks are discarded, pointers return to bank 0, and an in-flight rd_data_vld is suppressed immediately (async).
- Wrap-around: wr_bank and rd_bank are 1-bit and toggle 1->0 naturally; counters wrap at BANK_WORDS.

Test Plan:
- Reset release, no stimulus -> wr_ready=1, rd_avail=0, ram_we=0, ram_rd=0, rd_err=0.
- Write 16 words D0..D15 back-to-back -> ram_waddr 0..15, wr_blk_done pulse on word 15, rd_avail=1 next cycle, wr_ready stays 1 (bank 1 empty).
- Write 32 words with no reads -> addresses 0..31, wr_ready=0 from cycle after word 31; a 33rd wr_valid is held with no ram_we.
- After one full block, rd_en held 16 cycles -> ram_raddr 0..15, rd_data_vld cycles 1..16 later with data D0..D15, rd_last on D15, rd_avail=0 after.
- Concurrent: producer writing bank 1 while consumer reads bank 0, then consumer waits on bank 1 -> no data corruption, read order block0 then block1, full bits correct each cycle.
- rd_en with rd_avail=0 -> ram_rd=0, rd_err=1 sticky; rst mid-block (after 7 writes) -> all flags 0, next write goes to address 0.
